// File: rtl/fp_renormalizer_if.sv
// Handshake and data bundle between the adder tree, the renormalizer and
// the result register. The master drives sums in and accepts results; the
// renormalizer connects through the slave modport.
interface fp_renormalizer_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int SUM_W  = 51
);
  logic              in_valid;
  logic              in_ready;
  logic [SUM_W-1:0]  sum;
  logic [EXP_W-1:0]  exp_max;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-1:0] out_mant;
  logic              out_zero;
  logic              out_ovf;
  logic              out_unf;

  modport master (
    output in_valid, sum, exp_max, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant,
           out_zero, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, sum, exp_max, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant,
           out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/fp_renormalizer.sv
// fp_renormalizer: converts the signed fixed-point mantissa sum (aligned to
// exp_max, 1.0 at bit 2*MANT_W) back into sign / signed exponent / fraction.
// Three register stages (abs -> normalize -> round/range), valid/ready with
// a global stall so the pipeline holds as a unit.
// Define FP_RENORM_RNE_EN for round-to-nearest-even; otherwise the fraction
// is truncated toward zero and no guard/sticky logic exists.
module fp_renormalizer #(
  parameter int N      = 8,
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input logic              clk,
  input logic              rst,
  fp_renormalizer_if.slave bus
);
  localparam int SUM_W = 2*MANT_W + 2 + $clog2(N);
  localparam int PW    = $clog2(SUM_W);
  localparam int EW    = EXP_W + PW + 1;
  localparam logic signed [EW-1:0] E_MAX = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] E_MIN = EW'(-(2**(EXP_W-1)));

  logic stall;
  assign stall        = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Stage 1: sign and magnitude; the most negative sum still fits unsigned.
  logic                    v1, sign1;
  logic [SUM_W-1:0]        mag1;
  logic signed [EXP_W-1:0] exp1;

  // Stage 1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      mag1  <= '0;
      exp1  <= '0;
    end else if (!stall) begin
      v1    <= bus.in_valid;
      sign1 <= bus.sum[SUM_W-1];
      mag1  <= bus.sum[SUM_W-1] ? (SUM_W'(0) - bus.sum) : bus.sum;
      exp1  <= bus.exp_max;
    end
  end

  // Stage 2 combinational: leading-one position and normalize.
  logic [PW-1:0]          lead;
  logic [PW-1:0]          shamt;
  logic [MANT_W-1:0]      frac_s2;
  logic signed [EW-1:0]   e_s2;

  // Leading-one detect: highest set bit wins
  always_comb begin
    lead = '0;
    for (int i = 0; i < SUM_W; i++)
      if (mag1[i]) lead = PW'(i);
  end

  assign shamt = PW'(SUM_W-1) - lead;
  assign e_s2  = $signed(EW'(exp1)) + $signed(EW'({1'b0, lead})) - EW'(2*MANT_W);

`ifdef FP_RENORM_RNE_EN
  // Hidden bit sits at SUM_W-1 after the shift and is dropped here.
  logic [SUM_W-2:0] norm;
  logic             guard_s2, sticky_s2;
  assign norm      = (SUM_W-1)'(mag1 << shamt);
  assign frac_s2   = norm[SUM_W-2 -: MANT_W];
  assign guard_s2  = norm[SUM_W-2-MANT_W];
  assign sticky_s2 = |norm[SUM_W-3-MANT_W:0];
`else
  assign frac_s2   = MANT_W'((mag1 << shamt) >> (SUM_W-1-MANT_W));
`endif

  logic                 v2, sign2, zero2;
  logic [MANT_W-1:0]    frac2;
  logic signed [EW-1:0] e2;
`ifdef FP_RENORM_RNE_EN
  logic                 guard2, sticky2;
`endif

  // Stage 2 register
  always_ff @(posedge clk) begin
    if (rst) begin
      v2      <= 1'b0;
      sign2   <= 1'b0;
      zero2   <= 1'b0;
      frac2   <= '0;
      e2      <= '0;
`ifdef FP_RENORM_RNE_EN
      guard2  <= 1'b0;
      sticky2 <= 1'b0;
`endif
    end else if (!stall) begin
      v2      <= v1;
      sign2   <= sign1;
      zero2   <= (mag1 == '0);
      frac2   <= frac_s2;
      e2      <= e_s2;
`ifdef FP_RENORM_RNE_EN
      guard2  <= guard_s2;
      sticky2 <= sticky_s2;
`endif
    end
  end

  // Stage 3 combinational: rounding (may carry into the exponent).
  logic [MANT_W-1:0]    frac_r;
  logic signed [EW-1:0] e_r;

`ifdef FP_RENORM_RNE_EN
  logic rnd_inc, rnd_carry;

  // Round to nearest, ties to even
  always_comb begin
    rnd_inc = guard2 && (sticky2 || frac2[0]);
    {rnd_carry, frac_r} = {1'b0, frac2} + {{MANT_W{1'b0}}, rnd_inc};
    e_r = rnd_carry ? (e2 + EW'(1)) : e2;
  end
`else
  // Truncation: fraction and exponent pass straight through
  always_comb begin
    frac_r = frac2;
    e_r    = e2;
  end
`endif

  // Stage 3 register: zero, overflow saturation, underflow flush
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sign  <= 1'b0;
      bus.out_exp   <= '0;
      bus.out_mant  <= '0;
      bus.out_zero  <= 1'b0;
      bus.out_ovf   <= 1'b0;
      bus.out_unf   <= 1'b0;
    end else if (!stall) begin
      bus.out_valid <= v2;
      bus.out_sign  <= sign2;
      bus.out_exp   <= e_r[EXP_W-1:0];
      bus.out_mant  <= frac_r;
      bus.out_zero  <= 1'b0;
      bus.out_ovf   <= 1'b0;
      bus.out_unf   <= 1'b0;
      if (zero2) begin
        bus.out_sign <= 1'b0;
        bus.out_zero <= 1'b1;
        bus.out_exp  <= E_MIN[EXP_W-1:0];
        bus.out_mant <= '0;
      end else if (e_r > E_MAX) begin
        bus.out_exp  <= E_MAX[EXP_W-1:0];
        bus.out_mant <= '1;
        bus.out_ovf  <= 1'b1;
      end else if (e_r < E_MIN) begin
        bus.out_exp  <= E_MIN[EXP_W-1:0];
        bus.out_mant <= '0;
        bus.out_unf  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fp_renormalizer.sv
// Directed bench for fp_renormalizer at EXP_W=8, MANT_W=23, N=8 (SUM_W=51).
// Results are compared as packed {sign, exp, mant, zero, ovf, unf}.
module tb_fp_renormalizer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_renormalizer_if bus ();

  fp_renormalizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input logic s, input logic [7:0] e, input logic [22:0] m,
                                     input logic z, input logic o, input logic u);
    return 64'({s, e, m, z, o, u});
  endfunction

  function automatic logic [63:0] res();
    return 64'({bus.out_sign, bus.out_exp, bus.out_mant, bus.out_zero, bus.out_ovf, bus.out_unf});
  endfunction

  // One isolated transaction: checks 3-cycle latency and the result.
  task automatic single(input string tag, input logic [50:0] s, input logic [7:0] em,
                        input logic [63:0] want);
    @(negedge clk);
    bus.sum = s; bus.exp_max = em; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, " lat1"}, 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    chk({tag, " lat2"}, 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    chk({tag, " lat3"}, 64'(bus.out_valid), 64'(1));
    chk({tag, " result"}, res(), want);
  endtask

  int sent, got, extra;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.sum = '0; bus.exp_max = '0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset outputs", res(), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 64'(bus.in_ready), 64'(1));

    single("t1 unit",      51'(1) << 46,              8'd5,   pk(0, 8'd5,   23'h0,      0, 0, 0));
    single("t2 carry pos", 51'(3) << 46,              8'd5,   pk(0, 8'd6,   23'h400000, 0, 0, 0));
    single("t2 negative",  -(51'(1) << 46),           8'd5,   pk(1, 8'd5,   23'h0,      0, 0, 0));
    single("t3 cancel",    51'(1) << 10,              8'd0,   pk(0, 8'hDC,  23'h0,      0, 0, 0));
    single("t3 zero",      51'(0),                    8'd9,   pk(0, 8'h80,  23'h0,      1, 0, 0));
    single("t4 ovf",       51'(1) << 49,              8'd127, pk(0, 8'h7F,  23'h7FFFFF, 0, 1, 0));
    single("t4 at min",    51'(1) << 46,              8'h80,  pk(0, 8'h80,  23'h0,      0, 0, 0));
    single("t4 unf",       51'(1) << 45,              8'h80,  pk(0, 8'h80,  23'h0,      0, 0, 1));
    single("unf neg",      -(51'(1) << 45),           8'h80,  pk(1, 8'h80,  23'h0,      0, 0, 1));
    single("most neg",     51'(1) << 50,              8'd0,   pk(1, 8'd4,   23'h0,      0, 0, 0));
    single("tie even",     (51'(1) << 46) | (51'(1) << 22), 8'd0, pk(0, 8'd0, 23'h0, 0, 0, 0));
`ifdef FP_RENORM_RNE_EN
    single("t5 tie odd",   (51'(1) << 46) | (51'(1) << 23) | (51'(1) << 22), 8'd0,
           pk(0, 8'd0, 23'h2, 0, 0, 0));
    single("t5 carryout",  (51'(1) << 47) - 51'(1),   8'd0,   pk(0, 8'd1,   23'h0,      0, 0, 0));
    single("above half",   (51'(1) << 46) | (51'(1) << 22) | 51'(1), 8'd0,
           pk(0, 8'd0, 23'h1, 0, 0, 0));
`else
    single("t5 tie odd",   (51'(1) << 46) | (51'(1) << 23) | (51'(1) << 22), 8'd0,
           pk(0, 8'd0, 23'h1, 0, 0, 0));
    single("t5 carryout",  (51'(1) << 47) - 51'(1),   8'd0,   pk(0, 8'd0,   23'h7FFFFF, 0, 0, 0));
    single("above half",   (51'(1) << 46) | (51'(1) << 22) | 51'(1), 8'd0,
           pk(0, 8'd0, 23'h0, 0, 0, 0));
`endif

    // Stream of 10 with a 4-cycle output stall; item k: exp k-20, mant k<<17.
    @(negedge clk);
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.out_ready = !(cyc >= 4 && cyc < 8);
      bus.in_valid  = (sent < 10);
      bus.sum       = (51'(1) << 46) | (51'(sent) << 40);
      bus.exp_max   = 8'(sent - 20);
      #1;
      if (cyc == 5) chk("stall in_ready", 64'(bus.in_ready), 64'(0));
      if (bus.out_valid && bus.out_ready) begin
        chk("stream order", res(), pk(0, 8'(got - 20), 23'(got << 17), 0, 0, 0));
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("stream count", 64'(got), 64'(10));
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    chk("stream no dup", 64'(extra), 64'(0));

    // Reset with three items in flight: nothing may emerge afterwards.
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.sum = 51'(1) << 46; bus.exp_max = 8'(k); bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre-rst busy", 64'(bus.out_valid), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst in_ready", 64'(bus.in_ready), 64'(1));
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    chk("rst flushed", 64'(extra), 64'(0));
    single("post rst", 51'(1) << 47, 8'd3, pk(0, 8'd4, 23'h0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
